// File: rtl/fetch_stage.sv
// Instruction-fetch stage for the LC2K core: owns the PC, drives the word address
// to instruction memory and captures the returned word into the IF/ID register.
module fetch_stage #(
  parameter int                  PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = {PC_WIDTH{1'b0}},
  parameter int                  MEM_DEPTH = 10
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] pcCurrent,
  input  logic [31:0]         instr,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                if_valid,
  output logic [31:0]         if_instr,
  output logic [PC_WIDTH-1:0] if_pc,
  output logic [PC_WIDTH-1:0] if_pc_plus1,
  output logic                halted,
  output logic                fetch_fault,
  output logic [31:0]         fetch_count
);

  localparam logic [PC_WIDTH-1:0] MEM_LIMIT = PC_WIDTH'(MEM_DEPTH);
  localparam logic [PC_WIDTH-1:0] PC_ONE    = {{(PC_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_HALT_SEEN = 2'd1,
    ST_HALTED    = 2'd2
  } state_t;

  state_t                state_r;
  logic [PC_WIDTH-1:0]   pc_r;
  logic [PC_WIDTH-1:0]   pc_plus1_s;
  logic                  in_range_s;
  logic                  halt_s;

  assign pcCurrent = pc_r;

  // Next-address and fetch-qualification decode of the current PC and memory word.
  always_comb begin
    pc_plus1_s = pc_r + PC_ONE;
    in_range_s = (pc_r < MEM_LIMIT);
    halt_s     = (instr[24:22] == 3'b110);
  end

  // Fetch sequencer: PC, IF/ID register, halt tracking, fault flag and fetch counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_RUN;
      pc_r        <= RESET_PC;
      if_valid    <= 1'b0;
      if_instr    <= 32'd0;
      if_pc       <= {PC_WIDTH{1'b0}};
      if_pc_plus1 <= {PC_WIDTH{1'b0}};
      halted      <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_count <= 32'd0;
    end else if (redirect_valid) begin
      // Redirect flushes IF/ID and wins over both stall and a pending halt.
      pc_r     <= redirect_pc;
      state_r  <= ST_RUN;
      halted   <= 1'b0;
      if_valid <= 1'b0;
    end else if (stall) begin
      pc_r    <= pc_r;
      state_r <= state_r;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (!in_range_s) begin
            if_valid    <= 1'b0;
            fetch_fault <= 1'b1;
          end else begin
            if_instr    <= instr;
            if_pc       <= pc_r;
            if_pc_plus1 <= pc_plus1_s;
            if_valid    <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
            if (halt_s) begin
              state_r <= ST_HALT_SEEN;
            end else begin
              pc_r <= pc_plus1_s;
            end
          end
        end
        ST_HALT_SEEN: begin
          if_valid <= 1'b0;
          state_r  <= ST_HALTED;
          halted   <= 1'b1;
        end
        ST_HALTED: begin
          if_valid <= 1'b0;
        end
        default: begin
          if_valid <= 1'b0;
          state_r  <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by randomized
// stall/redirect/reset traffic, all compared against a cycle-level reference model.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic [31:0] pcCurrent;
  logic [31:0] instr;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus1;
  logic        halted;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  logic [31:0] mem [16];

  int checks = 0;
  int errors = 0;

  // Reference model state (what the stage should look like after each edge)
  logic [31:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_ifpc;
  logic [31:0] m_ifpc1;
  logic        m_halt_pending;
  logic        m_halted;
  logic        m_fault;
  logic [31:0] m_count;

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .pcCurrent      (pcCurrent),
    .instr          (instr),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .if_pc_plus1    (if_pc_plus1),
    .halted         (halted),
    .fetch_fault    (fetch_fault),
    .fetch_count    (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction memory; out-of-array addresses return a marker word.
  always_comb begin
    if (pcCurrent < 32'd16) instr = mem[pcCurrent[3:0]];
    else                    instr = 32'hDEAD_BEEF;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_halt(input logic [31:0] w);
    return (w[24:22] == 3'b110);
  endfunction

  // One clock of architectural behaviour, derived from the stage's rules.
  task automatic model_step();
    logic [31:0] w;
    if (reset) begin
      m_pc = 32'd0; m_valid = 1'b0; m_instr = 32'd0; m_ifpc = 32'd0; m_ifpc1 = 32'd0;
      m_halt_pending = 1'b0; m_halted = 1'b0; m_fault = 1'b0; m_count = 32'd0;
    end else if (redirect_valid) begin
      m_pc = redirect_pc; m_valid = 1'b0; m_halt_pending = 1'b0; m_halted = 1'b0;
    end else if (stall) begin
      m_pc = m_pc;
    end else if (m_halted) begin
      m_valid = 1'b0;
    end else if (m_halt_pending) begin
      m_valid = 1'b0; m_halt_pending = 1'b0; m_halted = 1'b1;
    end else if (m_pc >= 32'd10) begin
      m_valid = 1'b0; m_fault = 1'b1;
    end else begin
      w = mem[m_pc[3:0]];
      m_valid = 1'b1; m_instr = w; m_ifpc = m_pc; m_ifpc1 = m_pc + 32'd1;
      m_count = m_count + 32'd1;
      if (is_halt(w)) m_halt_pending = 1'b1;
      else            m_pc = m_pc + 32'd1;
    end
  endtask

  task automatic compare_all();
    check_eq("pcCurrent",   pcCurrent,   m_pc);
    check_eq("if_valid",    if_valid,    m_valid);
    check_eq("if_instr",    if_instr,    m_instr);
    check_eq("if_pc",       if_pc,       m_ifpc);
    check_eq("if_pc_plus1", if_pc_plus1, m_ifpc1);
    check_eq("halted",      halted,      m_halted);
    check_eq("fetch_fault", fetch_fault, m_fault);
    check_eq("fetch_count", fetch_count, m_count);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic r, input logic s, input logic rv, input logic [31:0] rp);
    reset = r; stall = s; redirect_valid = rv; redirect_pc = rp;
  endtask

  initial begin
    mem[0] = 32'h0081_000A; mem[1] = 32'h0082_000B; mem[2] = 32'h0083_0009;
    mem[3] = 32'h0000_0003; mem[4] = 32'h0000_0004; mem[5] = 32'h0000_0005;
    mem[6] = 32'h0000_0006; mem[7] = 32'h0000_0007; mem[8] = 32'h0180_0000;
    mem[9] = 32'h0000_0009;
    for (int i = 10; i < 16; i++) mem[i] = 32'h0000_0100 + 32'(i);

    drive(1'b1, 1'b0, 1'b0, 32'd0);
    step();
    check_eq("reset_pc", pcCurrent, 64'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0);

    // Sequential fetch with a two-cycle stall while IF/ID holds address 1
    step(); step();
    check_eq("pre_stall_if_pc", if_pc, 64'd1);
    drive(1'b0, 1'b1, 1'b0, 32'd0);
    step(); step();
    check_eq("stall_pc_hold", pcCurrent, 64'd2);
    check_eq("stall_instr_hold", if_instr, 64'h0082_000B);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    step();
    check_eq("release_if_pc", if_pc, 64'd2);
    check_eq("count_three", fetch_count, 64'd3);
    step();

    // Redirect together with stall: redirect wins
    drive(1'b0, 1'b1, 1'b1, 32'd7);
    step();
    check_eq("redir_pc", pcCurrent, 64'd7);
    check_eq("redir_flush", if_valid, 64'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    step();
    check_eq("redir_first_if_pc", if_pc, 64'd7);

    // Halt at address 8
    step();
    check_eq("halt_captured_pc", if_pc, 64'd8);
    step();
    check_eq("halted_flag", halted, 64'd1);
    for (int i = 0; i < 6; i++) step();
    check_eq("halted_pc_hold", pcCurrent, 64'd8);
    check_eq("halted_count", fetch_count, 64'd6);

    // Redirect onto the halt (redirect beats the halt word), then flush it from HALT_SEEN
    drive(1'b0, 1'b0, 1'b1, 32'd8);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    step();
    drive(1'b0, 1'b0, 1'b1, 32'd3);
    step();
    check_eq("halt_seen_redir_halted", halted, 64'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    step();
    check_eq("halt_seen_redir_if_pc", if_pc, 64'd3);

    // Out-of-range fetch is sticky until reset
    drive(1'b0, 1'b0, 1'b1, 32'd12);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    step(); step();
    check_eq("fault_set", fetch_fault, 64'd1);
    check_eq("fault_pc_hold", pcCurrent, 64'd12);
    drive(1'b0, 1'b0, 1'b1, 32'd0);
    step();
    drive(1'b0, 1'b0, 1'b0, 32'd0);
    step();
    check_eq("fault_resume_if_pc", if_pc, 64'd0);
    check_eq("fault_sticky", fetch_fault, 64'd1);
    drive(1'b1, 1'b1, 1'b0, 32'd0);
    step();
    check_eq("fault_reset_clear", fetch_fault, 64'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0);

    // Randomized traffic against the model with fresh memory contents
    for (int i = 0; i < 10; i++) begin
      mem[i] = $urandom;
      if ($urandom_range(0, 4) == 0) mem[i][24:22] = 3'b110;
      else if (mem[i][24:22] == 3'b110) mem[i][22] = 1'b1;
    end
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 9) == 0),
            32'($urandom_range(0, 13)));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the LC2K core; sits directly upstream of the instruction memory.
- Owns the program counter and drives the word address to the memory, which returns the instruction combinationally.
- Captures the returned word into an IF/ID pipeline register.
- Handles stall from decode, redirect from branch/jalr resolution, halt detection, and out-of-range fetch faults.

Parameters:
- PC_WIDTH, 32, width of PC and all address ports
- RESET_PC, 0, PC value loaded on reset
- MEM_DEPTH, 10, number of valid instruction words; PC >= MEM_DEPTH is a fetch fault

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- pcCurrent  output  PC_WIDTH  word address to instruction memory (equals PC register)
- instr  input  32  instruction word from memory, combinational from pcCurrent
- stall  input  1  decode cannot accept; hold PC and IF/ID
- redirect_valid  input  1  taken beq/jalr resolved; load redirect_pc
- redirect_pc  input  PC_WIDTH  redirect target
- if_valid  output  1  IF/ID holds a real instruction
- if_instr  output  32  IF/ID instruction
- if_pc  output  PC_WIDTH  address of if_instr
- if_pc_plus1  output  PC_WIDTH  if_pc + 1 (for beq/jalr)
- halted  output  1  fetch stopped after halt consumed
- fetch_fault  output  1  sticky: fetch attempted at PC >= MEM_DEPTH
- fetch_count  output  32  instructions captured into IF/ID

Behaviour:
- Reset (synchronous, dominant over everything):
  - PC = RESET_PC, state = RUN
  - if_valid = 0, if_instr = 0, if_pc = 0, if_pc_plus1 = 0
  - halted = 0, fetch_fault = 0, fetch_count = 0
- PC is word-addressed and increments by 1, wrapping modulo 2^PC_WIDTH. if_pc_plus1 is computed with the same wrap.
- Halt detect: instr[24:22] == 3'b110.
- States:
  - RUN: fetching
  - HALT_SEEN: halt sits in IF/ID, not yet consumed
  - HALTED: fetch stopped
- Per-cycle priority: reset > redirect_valid > stall > normal.
- redirect_valid (any state):
  - PC <= redirect_pc; state <= RUN; halted <= 0
  - if_valid <= 0 (flush); fetch_count unchanged
  - stall is ignored this cycle
- stall=1, no redirect: PC, IF/ID, state and fetch_count all hold.
- Normal cycle in RUN:
  - If PC >= MEM_DEPTH: if_valid <= 0, fetch_fault <= 1, PC holds, state stays RUN. A later redirect to an in-range PC resumes fetch, but fetch_fault stays set.
  - Else:
    - if_instr <= instr, if_pc <= PC, if_pc_plus1 <= PC+1, if_valid <= 1
    - fetch_count <= fetch_count + 1
    - If halt detected: PC holds, state <= HALT_SEEN
    - Otherwise: PC <= PC+1
- Normal cycle in HALT_SEEN: the halt is consumed this cycle. if_valid <= 0, state <= HALTED, halted <= 1.
- Normal cycle in HALTED: nothing changes; if_valid stays 0; pcCurrent stays at the halt's address.
- Latency: the instruction at address A appears on if_instr one cycle after pcCurrent = A with stall low. Redirect-to-first-valid also takes one cycle.
- Simultaneous redirect and halt in memory output: the redirect wins and the halt is not captured.
- Reset mid-stall or mid-halt returns to the reset state next cycle, with no residual valid.

Test Plan:
- Reset, then run 3 cycles with memory words 0x0081000A, 0x0082000B, 0x00830009 -> if_valid = 1 each cycle; if_pc = 0, 1, 2; if_pc_plus1 = 1, 2, 3; fetch_count = 3.
- Stall held 2 cycles while if_pc = 1 -> pcCurrent stays 2, if_instr stays 0x0082000B, fetch_count unchanged; release -> if_pc = 2 next cycle.
- redirect_valid with redirect_pc = 7 together with stall = 1 at pcCurrent = 4 -> next cycle if_valid = 0 and pcCurrent = 7; following cycle if_pc = 7.
- Halt 0x01800000 at address 8 -> if_pc = 8 and if_valid = 1; next cycle if_valid = 0 and halted = 1; pcCurrent stays 8 for 5+ cycles; fetch_count frozen.
- Halt in HALT_SEEN with redirect_valid and redirect_pc = 3 -> state returns to RUN, halted = 0, halt flushed; if_pc = 3 on the following cycle.
- redirect_pc = 12 with MEM_DEPTH = 10 -> fetch_fault = 1, if_valid = 0, pcCurrent stays 12; redirect to 0 -> fetch resumes at 0 while fetch_fault stays 1; reset clears fetch_fault.
